// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe: pipelined signed fixed-point multiplier with per-beat Q formats.
//   Computes c = a*b re-aligned from (num_frac_a + num_frac_b) to num_frac_c
//   fractional bits, with truncate/round-half-up and wrap/saturate per beat.
//   The whole pipeline advances together under valid/ready flow control.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       input handshake (in_ready is combinational)
//   a, b                      signed operands (WA, WB bits)
//   num_frac_a/_b/_c          per-beat fractional bit counts (WF bits, unsigned)
//   round_en, sat_en          per-beat rounding and saturation modes
//   out_valid / out_ready     output handshake
//   c, ovf                    signed result (WC bits) and overflow flag
// Latency: a beat accepted at a rising edge is presented PIPE edges later
//   (input rank, product rank, PIPE-1 result ranks). Throughput 1 beat/cycle.
module fxp_mul_pipe #(
    parameter int unsigned WA   = 14,
    parameter int unsigned WB   = 14,
    parameter int unsigned WC   = 29,
    parameter int unsigned PIPE = 3,
    parameter int unsigned WF   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WA-1:0] a,
    input  logic signed [WB-1:0] b,
    input  logic        [WF-1:0] num_frac_a,
    input  logic        [WF-1:0] num_frac_b,
    input  logic        [WF-1:0] num_frac_c,
    input  logic                 round_en,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WC-1:0] c,
    output logic                 ovf
);

    localparam int unsigned WP  = WA + WB;          // full product width
    localparam int unsigned WS  = WF + 2;           // signed alignment shift width
    localparam int unsigned WX  = WP + WC + 2;      // headroom for left shift by up to WC
    localparam int unsigned SHW = $clog2(WX + 1);   // shift amount width
    localparam int unsigned NR  = PIPE - 1;         // result ranks incl. output rank

    localparam logic signed [WX-1:0] ONE_X  = WX'(1);
    localparam logic signed [WX-1:0] C_MAX  = {{(WX-WC+1){1'b0}}, {(WC-1){1'b1}}};
    localparam logic signed [WX-1:0] C_MIN  = {{(WX-WC+1){1'b1}}, {(WC-1){1'b0}}};
    localparam logic        [WC-1:0] SAT_HI = {1'b0, {(WC-1){1'b1}}};
    localparam logic        [WC-1:0] SAT_LO = {1'b1, {(WC-1){1'b0}}};

    logic adv;

    // Stage 1: captured operands, formats and modes
    logic                 s1_v;
    logic signed [WA-1:0] s1_a;
    logic signed [WB-1:0] s1_b;
    logic        [WF-1:0] s1_fa;
    logic        [WF-1:0] s1_fb;
    logic        [WF-1:0] s1_fc;
    logic                 s1_rnd;
    logic                 s1_sat;

    // Stage 2: full-precision product and signed alignment shift
    logic                 s2_v;
    logic signed [WP-1:0] s2_p;
    logic signed [WS-1:0] s2_s;
    logic                 s2_rnd;
    logic                 s2_sat;

    // Alignment / rounding / range logic feeding the first result rank
    logic signed [31:0]   s_wide;
    logic signed [31:0]   neg;
    logic signed [WX-1:0] pe;
    logic signed [WX-1:0] rnd_add;
    logic signed [WX-1:0] v;
    logic        [SHW-1:0] rsh;
    logic        [SHW-1:0] lsh;
    logic signed [WC-1:0] c_nx;
    logic                 ovf_nx;

    // Result ranks; the last one drives the outputs
    logic        [NR-1:0] r_v;
    logic signed [WC-1:0] r_c   [NR];
    logic                 r_ovf [NR];

    // Whole pipeline moves only when the output slot is free or being drained
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = r_v[NR-1];
    assign c         = r_c[NR-1];
    assign ovf       = r_ovf[NR-1];

    // Stage valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (adv) begin
            s1_v <= in_valid;
            s2_v <= s1_v;
        end
    end

    // Stage 1/2 payload; contents of invalid stages are don't-care
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a   <= a;
            s1_b   <= b;
            s1_fa  <= num_frac_a;
            s1_fb  <= num_frac_b;
            s1_fc  <= num_frac_c;
            s1_rnd <= round_en;
            s1_sat <= sat_en;
            s2_p   <= WP'(s1_a) * WP'(s1_b);
            s2_s   <= $signed({2'b00, s1_fa}) + $signed({2'b00, s1_fb})
                    - $signed({2'b00, s1_fc});
            s2_rnd <= s1_rnd;
            s2_sat <= s1_sat;
        end
    end

    // Align product to the output format.
    // Right shifts clamp at WP: beyond that the result is already 0 / -1 (0 when rounding).
    // Left shifts clamp at WC: any nonzero product is then out of range and its
    // low WC bits are zero, so both ovf and the wrapped value stay exact.
    always_comb begin
        s_wide  = 32'(s2_s);
        neg     = -s_wide;
        pe      = WX'(s2_p);
        rsh     = '0;
        lsh     = '0;
        rnd_add = '0;
        v       = pe;
        if (s_wide > 0) begin
            rsh     = (s_wide >= WP) ? SHW'(WP) : SHW'(s_wide);
            rnd_add = s2_rnd ? (ONE_X << (rsh - SHW'(1))) : '0;
            v       = (pe + rnd_add) >>> rsh;
        end else if (s_wide < 0) begin
            lsh = (neg >= WC) ? SHW'(WC) : SHW'(neg);
            v   = pe <<< lsh;
        end
        ovf_nx = (v > C_MAX) || (v < C_MIN);
        if (ovf_nx && s2_sat) begin
            c_nx = v[WX-1] ? SAT_LO : SAT_HI;
        end else begin
            c_nx = v[WC-1:0];
        end
    end

    // Result ranks: first captures the aligned result, the rest retime it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            for (int i = 0; i < int'(NR); i++) begin
                r_c[i]   <= '0;
                r_ovf[i] <= 1'b0;
            end
        end else if (adv) begin
            r_v[0]   <= s2_v;
            r_c[0]   <= c_nx;
            r_ovf[0] <= ovf_nx;
            for (int i = 1; i < int'(NR); i++) begin
                r_v[i]   <= r_v[i-1];
                r_c[i]   <= r_c[i-1];
                r_ovf[i] <= r_ovf[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// tb_fxp_mul_pipe: directed and randomized checks of fxp_mul_pipe against a
// longint reference model of the fixed-point multiply/align/round/saturate rules.
module tb_fxp_mul_pipe;

    localparam int WA    = 14;
    localparam int WB    = 14;
    localparam int WC    = 29;
    localparam int WF    = 8;
    localparam int PIPE  = 3;
    localparam int PIPE5 = 5;
    localparam longint CMAX = (longint'(1) << (WC - 1)) - 1;
    localparam longint CMIN = -(longint'(1) << (WC - 1));

    typedef struct {
        int a;
        int b;
        int fa;
        int fb;
        int fc;
        bit rnd;
        bit sat;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [WA-1:0] a;
    logic signed [WB-1:0] b;
    logic        [WF-1:0] fa;
    logic        [WF-1:0] fb;
    logic        [WF-1:0] fc;
    logic                 round_en;
    logic                 sat_en;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [WC-1:0] c;
    logic                 ovf;

    logic                 in_valid5;
    logic                 in_ready5;
    logic                 out_valid5;
    logic                 out_ready5;
    logic signed [WC-1:0] c5;
    logic                 ovf5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fxp_mul_pipe #(.WA(WA), .WB(WB), .WC(WC), .PIPE(PIPE), .WF(WF)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .num_frac_a(fa), .num_frac_b(fb), .num_frac_c(fc),
        .round_en(round_en), .sat_en(sat_en), .out_valid(out_valid),
        .out_ready(out_ready), .c(c), .ovf(ovf)
    );

    fxp_mul_pipe #(.WA(WA), .WB(WB), .WC(WC), .PIPE(PIPE5), .WF(WF)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .a(a), .b(b), .num_frac_a(fa), .num_frac_b(fb), .num_frac_c(fc),
        .round_en(round_en), .sat_en(sat_en), .out_valid(out_valid5),
        .out_ready(out_ready5), .c(c5), .ovf(ovf5)
    );

    // Exact value of a*b * 2^-(fa+fb-fc), floored (optionally after +half), then range-checked
    function automatic void ref_model(input beat_t bt, output logic signed [WC-1:0] ec,
                                      output bit eo);
        longint p;
        longint v;
        int     s;
        p = longint'(bt.a) * longint'(bt.b);
        s = bt.fa + bt.fb - bt.fc;
        v = 0;
        if (s > 0) begin
            if (s >= 62)     v = (bt.rnd || p >= 0) ? 0 : -1;
            else if (bt.rnd) v = (p + (longint'(1) << (s - 1))) >>> s;
            else             v = p >>> s;
        end else if (s < 0) begin
            if (p != 0 && -s >= 34) begin
                // magnitude at least 2^34: out of range, low WC bits all zero
                eo = 1'b1;
                ec = bt.sat ? ((p > 0) ? WC'(CMAX) : WC'(CMIN)) : '0;
                return;
            end
            v = (p == 0) ? 0 : (p <<< (-s));
        end else begin
            v = p;
        end
        eo = (v > CMAX) || (v < CMIN);
        if (eo && bt.sat) ec = (v > 0) ? WC'(CMAX) : WC'(CMIN);
        else              ec = WC'(v);
    endfunction

    function automatic beat_t rand_beat();
        beat_t bt;
        bt.a = int'($urandom_range(0, (1 << WA) - 1)) - (1 << (WA - 1));
        bt.b = int'($urandom_range(0, (1 << WB) - 1)) - (1 << (WB - 1));
        if ($urandom_range(0, 9) == 0) bt.a = -(1 << (WA - 1));
        if ($urandom_range(0, 9) == 0) bt.b = -(1 << (WB - 1));
        case ($urandom_range(0, 4))
            0: begin
                bt.fa = int'($urandom_range(0, 255));
                bt.fb = int'($urandom_range(0, 255));
                bt.fc = int'($urandom_range(0, 255));
            end
            default: begin
                bt.fa = int'($urandom_range(0, 13));
                bt.fb = int'($urandom_range(0, 13));
                bt.fc = int'($urandom_range(0, 30));
            end
        endcase
        bt.rnd = 1'($urandom_range(0, 1));
        bt.sat = 1'($urandom_range(0, 1));
        return bt;
    endfunction

    task automatic drive_beat(input beat_t bt);
        a        = WA'(bt.a);
        b        = WB'(bt.b);
        fa       = WF'(bt.fa);
        fb       = WF'(bt.fb);
        fc       = WF'(bt.fc);
        round_en = bt.rnd;
        sat_en   = bt.sat;
    endtask

    // One beat through the PIPE=3 instance; lat = edges from accepting edge to output
    task automatic apply_beat(input beat_t bt, output logic signed [WC-1:0] oc,
                              output logic oo, output int lat);
        @(negedge clk);
        drive_beat(bt);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        oc = c;
        oo = ovf;
    endtask

    task automatic test_reset();
        beat_t z;
        z = '{a:0, b:0, fa:0, fb:0, fc:0, rnd:1'b0, sat:1'b0};
        drive_beat(z);
        rst = 1'b1; in_valid = 1'b0; in_valid5 = 1'b0;
        out_ready = 1'b1; out_ready5 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (c !== '0) begin n_fail++; $display("FAIL reset_c: got %0d want 0", c); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_valid5 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid5: got %b want 0", out_valid5); end
    endtask

    task automatic test_basic();
        beat_t bt;
        logic signed [WC-1:0] oc;
        logic oo;
        int lat;
        bt = '{a:3, b:5, fa:1, fb:1, fc:2, rnd:1'b0, sat:1'b0};
        apply_beat(bt, oc, oo, lat);
        n_tests++; if (oc !== WC'(15)) begin n_fail++; $display("FAIL basic_c: got %0d want 15", oc); end
        n_tests++; if (oo !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", oo); end
        n_tests++; if (lat != PIPE) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, PIPE); end
    endtask

    task automatic test_rounding();
        int av[4]  = '{3, 3, -3, -3};
        bit rv[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        int exv[4] = '{1, 2, -2, -1};
        beat_t bt;
        logic signed [WC-1:0] oc;
        logic oo;
        int lat;
        for (int i = 0; i < 4; i++) begin
            bt = '{a:av[i], b:1, fa:1, fb:1, fc:1, rnd:rv[i], sat:1'b0};
            apply_beat(bt, oc, oo, lat);
            n_tests++;
            if (oc !== WC'(exv[i]) || oo !== 1'b0) begin
                n_fail++;
                $display("FAIL rounding[%0d]: got c=%0d ovf=%b want c=%0d ovf=0", i, oc, oo, exv[i]);
            end
        end
    endtask

    task automatic test_saturation();
        beat_t bt;
        logic signed [WC-1:0] oc;
        logic oo;
        int lat;
        bt = '{a:-8192, b:-8192, fa:0, fb:0, fc:2, rnd:1'b0, sat:1'b1};
        apply_beat(bt, oc, oo, lat);
        n_tests++; if (oc !== WC'(268435455)) begin n_fail++; $display("FAIL sat_c: got %0d want 268435455", oc); end
        n_tests++; if (oo !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", oo); end
        bt.sat = 1'b0;
        apply_beat(bt, oc, oo, lat);
        n_tests++; if (oc !== WC'(-268435456)) begin n_fail++; $display("FAIL wrap_c: got %0d want -268435456", oc); end
        n_tests++; if (oo !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", oo); end
    endtask

    task automatic test_huge_shift();
        beat_t bt;
        logic signed [WC-1:0] oc;
        logic oo;
        int lat;
        bt = '{a:-1, b:1, fa:40, fb:40, fc:0, rnd:1'b0, sat:1'b0};
        apply_beat(bt, oc, oo, lat);
        n_tests++; if (oc !== WC'(-1) || oo !== 1'b0) begin n_fail++; $display("FAIL huge_trunc: got c=%0d ovf=%b want c=-1 ovf=0", oc, oo); end
        bt.rnd = 1'b1;
        apply_beat(bt, oc, oo, lat);
        n_tests++; if (oc !== WC'(0) || oo !== 1'b0) begin n_fail++; $display("FAIL huge_round: got c=%0d ovf=%b want c=0 ovf=0", oc, oo); end
    endtask

    task automatic test_back_to_back();
        int k_sent = 0;
        int k_got  = 0;
        int cyc    = 0;
        bit stall;
        bit have_held = 1'b0;
        logic signed [WC-1:0] held = '0;
        fa = '0; fb = '0; fc = '0; round_en = 1'b0; sat_en = 1'b0; b = WB'(2);
        while ((k_sent < 20 || k_got < 20) && cyc < 200) begin
            @(negedge clk);
            stall     = (cyc >= 8 && cyc < 12);
            out_ready = !stall;
            in_valid  = (k_sent < 20);
            a         = WA'(k_sent);
            #1;
            if (stall) begin
                n_tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_ready: cyc %0d got in_ready=%b out_valid=%b want 0/1", cyc, in_ready, out_valid);
                end
                if (have_held) begin
                    n_tests++;
                    if (c !== held) begin n_fail++; $display("FAIL stall_c_stable: cyc %0d got %0d want %0d", cyc, c, held); end
                end
                held = c;
                have_held = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (c !== WC'(2 * k_got) || ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ramp[%0d]: got c=%0d ovf=%b want c=%0d ovf=0", k_got, c, ovf, 2 * k_got);
                end
                k_got++;
            end
            if (in_valid && in_ready) k_sent++;
            cyc++;
        end
        in_valid = 1'b0;
        n_tests++; if (k_got != 20 || k_sent != 20) begin n_fail++; $display("FAIL ramp_count: got %0d results %0d sent want 20/20", k_got, k_sent); end
        for (int i = 0; i < PIPE + 2; i++) begin
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_extra_beat: got out_valid=%b want 0", out_valid); end
        end
    endtask

    task automatic test_bubbles_reset();
        beat_t ba;
        beat_t bb;
        beat_t bc;
        logic signed [WC-1:0] oc;
        logic oo;
        int lat;
        ba = '{a:5, b:7, fa:0, fb:0, fc:0, rnd:1'b0, sat:1'b0};
        bb = '{a:6, b:7, fa:0, fb:0, fc:0, rnd:1'b0, sat:1'b0};
        bc = '{a:-7, b:9, fa:0, fb:0, fc:0, rnd:1'b0, sat:1'b0};
        out_ready = 1'b1;
        @(negedge clk); drive_beat(ba); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); drive_beat(bb); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_pre_reset: got out_valid=%b want 0", out_valid); end
        @(negedge clk); rst = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || c !== '0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL midreset_flush: got out_valid=%b c=%0d ovf=%b want 0/0/0", out_valid, c, ovf);
        end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < PIPE + 3; i++) begin
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale_beat: got out_valid=%b want 0", out_valid); end
        end
        apply_beat(bc, oc, oo, lat);
        n_tests++; if (oc !== WC'(-63) || oo !== 1'b0) begin n_fail++; $display("FAIL post_reset_c: got c=%0d ovf=%b want -63/0", oc, oo); end
        n_tests++; if (lat != PIPE) begin n_fail++; $display("FAIL post_reset_latency: got %0d want %0d", lat, PIPE); end
    endtask

    task automatic test_random();
        beat_t q[$];
        beat_t cur;
        beat_t exp_bt;
        bit pending = 1'b0;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic signed [WC-1:0] ec;
        bit eo;
        cur = rand_beat();
        while ((sent < 300 || got < sent) && cyc < 5000) begin
            @(negedge clk);
            if (!pending && sent < 300 && $urandom_range(0, 3) != 0) begin
                cur = rand_beat();
                pending = 1'b1;
            end
            drive_beat(cur);
            in_valid  = pending;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_unexpected: got c=%0d with nothing outstanding", c);
                end else begin
                    exp_bt = q.pop_front();
                    ref_model(exp_bt, ec, eo);
                    if (c !== ec || ovf !== eo) begin
                        n_fail++;
                        $display("FAIL rand[%0d]: a=%0d b=%0d f=%0d/%0d/%0d r=%b s=%b got c=%0d ovf=%b want c=%0d ovf=%b",
                                 got, exp_bt.a, exp_bt.b, exp_bt.fa, exp_bt.fb, exp_bt.fc,
                                 exp_bt.rnd, exp_bt.sat, c, ovf, ec, eo);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(cur);
                sent++;
                pending = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_tests++; if (got != 300 || sent != 300) begin n_fail++; $display("FAIL rand_count: got %0d results %0d sent want 300/300", got, sent); end
    endtask

    task automatic test_pipe5();
        bit rv[2]  = '{1'b0, 1'b1};
        int exv[2] = '{-1, 0};
        beat_t bt;
        int lat;
        for (int i = 0; i < 2; i++) begin
            bt = '{a:-1, b:1, fa:40, fb:40, fc:0, rnd:rv[i], sat:1'b0};
            @(negedge clk);
            drive_beat(bt);
            in_valid5  = 1'b1;
            out_ready5 = 1'b1;
            @(negedge clk);
            in_valid5 = 1'b0;
            lat = 0;
            while (!out_valid5 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_tests++; if (lat != PIPE5) begin n_fail++; $display("FAIL pipe5_latency[%0d]: got %0d want %0d", i, lat, PIPE5); end
            n_tests++; if (c5 !== WC'(exv[i]) || ovf5 !== 1'b0) begin
                n_fail++; $display("FAIL pipe5_c[%0d]: got c=%0d ovf=%b want c=%0d ovf=0", i, c5, ovf5, exv[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_huge_shift();
        test_back_to_back();
        test_bubbles_reset();
        test_random();
        test_pipe5();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
